// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator. The active timing set is updated from a
// double-buffered pending set only at a frame boundary (or while idle), so a mode change
// never tears a frame.
module video_timing_gen #(
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned RST_H_ACTIVE = 1280,
  parameter int unsigned RST_H_FP     = 110,
  parameter int unsigned RST_H_SYNC   = 40,
  parameter int unsigned RST_H_BP     = 220,
  parameter int unsigned RST_V_ACTIVE = 720,
  parameter int unsigned RST_V_FP     = 5,
  parameter int unsigned RST_V_SYNC   = 5,
  parameter int unsigned RST_V_BP     = 20,
  parameter bit          RST_HS_POL   = 1'b1,
  parameter bit          RST_VS_POL   = 1'b1,
  parameter int unsigned PRE          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  input  logic             cfg_load,
  output logic             cfg_pending,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             de_pre,
  output logic [CNT_W-1:0] active_x,
  output logic [CNT_W-1:0] active_y,
  output logic             line_start,
  output logic             frame_start
);

  // One extra bit so porch/active sums cannot silently wrap.
  localparam int unsigned W1 = CNT_W + 1;

  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic             hs_pol;
    logic             vs_pol;
  } timing_t;

  localparam timing_t RstTiming = '{
    h_active: CNT_W'(RST_H_ACTIVE), h_fp: CNT_W'(RST_H_FP),
    h_sync:   CNT_W'(RST_H_SYNC),   h_bp: CNT_W'(RST_H_BP),
    v_active: CNT_W'(RST_V_ACTIVE), v_fp: CNT_W'(RST_V_FP),
    v_sync:   CNT_W'(RST_V_SYNC),   v_bp: CNT_W'(RST_V_BP),
    hs_pol:   RST_HS_POL,           vs_pol: RST_VS_POL
  };

  timing_t act_q, act_d, pend_set_q, pend_set_d, cfg_in;
  logic    pend_vld_q, pend_vld_d, apply;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [W1-1:0]    h_ext, v_ext, ha0, ha1, ht, va0, va1, vt, h_pre;
  logic             h_last, v_last;

  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, de_pre_q, de_pre_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             h_act, v_act, pre_act;

  assign cfg_in = '{
    h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
    hs_pol:   cfg_hs_pol,   vs_pol: cfg_vs_pol
  };

  // Region boundaries of the active set and end-of-line / end-of-frame detection.
  always_comb begin
    h_ext  = {1'b0, h_q};
    v_ext  = {1'b0, v_q};
    ha0    = W1'(act_q.h_sync) + W1'(act_q.h_bp);
    ha1    = ha0 + W1'(act_q.h_active);
    ht     = ha1 + W1'(act_q.h_fp);
    va0    = W1'(act_q.v_sync) + W1'(act_q.v_bp);
    va1    = va0 + W1'(act_q.v_active);
    vt     = va1 + W1'(act_q.v_fp);
    // >= rather than == so an illegal (shrunken or zero) total still wraps.
    h_last = (h_ext + W1'(1)) >= ht;
    v_last = (v_ext + W1'(1)) >= vt;
  end

  // Raster counters: held at the frame origin while disabled.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + CNT_W'(1);
    end else begin
      h_d = h_q + CNT_W'(1);
    end
  end

  // Pending-set capture and transfer; a load on the wrap edge stays pending for a frame.
  always_comb begin
    apply      = pend_vld_q & (~en | (h_last & v_last));
    act_d      = apply ? pend_set_q : act_q;
    pend_set_d = cfg_load ? cfg_in : pend_set_q;
    pend_vld_d = cfg_load | (pend_vld_q & ~apply);
  end

  // Output decode of the current counter state, registered one cycle later.
  always_comb begin
    h_act    = (h_ext >= ha0) && (h_ext < ha1);
    v_act    = (v_ext >= va0) && (v_ext < va1);
    h_pre    = h_ext + W1'(PRE);
    pre_act  = (h_pre >= ha0) && (h_pre < ha1);
    hs_d     = ~act_q.hs_pol;
    vs_d     = ~act_q.vs_pol;
    de_d     = 1'b0;
    de_pre_d = 1'b0;
    ls_d     = 1'b0;
    fs_d     = 1'b0;
    x_d      = '0;
    y_d      = '0;
    if (en) begin
      hs_d     = act_q.hs_pol ^ ~(h_ext < W1'(act_q.h_sync));
      vs_d     = act_q.vs_pol ^ ~(v_ext < W1'(act_q.v_sync));
      de_d     = h_act & v_act;
      de_pre_d = pre_act & v_act;
      ls_d     = (h_q == '0);
      fs_d     = (h_q == '0) && (v_q == '0);
      if (de_d) begin
        x_d = CNT_W'(h_ext - ha0);
        y_d = CNT_W'(v_ext - va0);
      end
    end
  end

  // Counter and configuration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      act_q      <= RstTiming;
      pend_set_q <= RstTiming;
      pend_vld_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      act_q      <= act_d;
      pend_set_q <= pend_set_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q     <= ~RST_HS_POL;
      vs_q     <= ~RST_VS_POL;
      de_q     <= 1'b0;
      de_pre_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      de_pre_q <= de_pre_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign cfg_pending = pend_vld_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign de_pre      = de_pre_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign active_x    = x_q;
  assign active_y    = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a behavioural raster model pushes the expected output word for
// every clock into a scoreboard queue; each scenario task pops and compares after the edge.
module tb_video_timing_gen;

  localparam int Pre = 2;

  logic        clk = 1'b0;
  logic        rst, en, cfg_load, cfg_hs_pol, cfg_vs_pol;
  logic [11:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [11:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic        cfg_pending, hs, vs, de, de_pre, line_start, frame_start;
  logic [11:0] active_x, active_y;

  always #5 clk = ~clk;

  video_timing_gen #(.CNT_W(12), .PRE(Pre)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync),
    .cfg_h_bp(cfg_h_bp), .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
    .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_hs_pol(cfg_hs_pol),
    .cfg_vs_pol(cfg_vs_pol), .cfg_load(cfg_load), .cfg_pending(cfg_pending),
    .hs(hs), .vs(vs), .de(de), .de_pre(de_pre), .active_x(active_x), .active_y(active_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [11:0] ha, hf, hsy, hb, va, vf, vsy, vb;
    logic        hp, vp;
  } mode_t;

  localparam mode_t ModeDef = '{ha: 12'd1280, hf: 12'd110, hsy: 12'd40, hb: 12'd220,
                                va: 12'd720, vf: 12'd5, vsy: 12'd5, vb: 12'd20,
                                hp: 1'b1, vp: 1'b1};
  localparam mode_t ModeSmall = '{ha: 12'd4, hf: 12'd1, hsy: 12'd2, hb: 12'd1,
                                  va: 12'd3, vf: 12'd1, vsy: 12'd1, vb: 12'd1,
                                  hp: 1'b1, vp: 1'b1};
  localparam mode_t ModeSmallN = '{ha: 12'd4, hf: 12'd1, hsy: 12'd2, hb: 12'd1,
                                   va: 12'd3, vf: 12'd1, vsy: 12'd1, vb: 12'd1,
                                   hp: 1'b0, vp: 1'b0};

  int          checks = 0;
  int          errors = 0;
  mode_t       m_act, m_pend;
  logic        m_pvld;
  int          m_h, m_v;
  logic [30:0] sb[$];
  logic [30:0] exp_v;
  logic [30:0] dut_v;

  // {pending, hs, vs, de, de_pre, line_start, frame_start, x, y}
  assign dut_v = {cfg_pending, hs, vs, de, de_pre, line_start, frame_start, active_x, active_y};

  function automatic logic [30:0] model_out(input mode_t m, input int h, input int v);
    int          ha0, va0;
    logic        hv, vv, vin, dv, pv;
    logic [11:0] xv, yv;
    ha0 = int'(m.hsy) + int'(m.hb);
    va0 = int'(m.vsy) + int'(m.vb);
    hv  = (h < int'(m.hsy)) ? m.hp : ~m.hp;
    vv  = (v < int'(m.vsy)) ? m.vp : ~m.vp;
    vin = (v >= va0) && (v < va0 + int'(m.va));
    dv  = (h >= ha0) && (h < ha0 + int'(m.ha)) && vin;
    pv  = (h >= ha0 - Pre) && (h < ha0 + int'(m.ha) - Pre) && vin;
    xv  = dv ? 12'(h - ha0) : 12'd0;
    yv  = dv ? 12'(v - va0) : 12'd0;
    return {1'b0, hv, vv, dv, pv, h == 0, (h == 0) && (v == 0), xv, yv};
  endfunction

  // Expected word for the clock about to happen, then advance the model raster.
  task automatic step_model(input logic load, input mode_t cfg);
    logic [30:0] e;
    int          ht, vt;
    e  = model_out(m_act, m_h, m_v);
    ht = int'(m_act.hsy) + int'(m_act.hb) + int'(m_act.ha) + int'(m_act.hf);
    vt = int'(m_act.vsy) + int'(m_act.vb) + int'(m_act.va) + int'(m_act.vf);
    m_h++;
    if (m_h >= ht) begin
      m_h = 0;
      m_v++;
      if (m_v >= vt) begin
        m_v = 0;
        if (m_pvld) begin
          m_act  = m_pend;
          m_pvld = 1'b0;
        end
      end
    end
    if (load) begin
      m_pend = cfg;
      m_pvld = 1'b1;
    end
    e[30] = m_pvld;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input mode_t m);
    cfg_h_active = m.ha;  cfg_h_fp = m.hf;  cfg_h_sync = m.hsy;  cfg_h_bp = m.hb;
    cfg_v_active = m.va;  cfg_v_fp = m.vf;  cfg_v_sync = m.vsy;  cfg_v_bp = m.vb;
    cfg_hs_pol   = m.hp;  cfg_vs_pol = m.vp;
  endtask

  task automatic model_reset(input mode_t m);
    m_act  = m;
    m_pend = m;
    m_pvld = 1'b0;
    m_h    = 0;
    m_v    = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    set_cfg(ModeDef);
    #1;
    checks++;
    if (dut_v !== 31'd0) begin
      errors++; $display("FAIL reset_async got %h exp %h", dut_v, 31'd0);
    end
    @(posedge clk); #1;
    checks++;
    if (dut_v !== 31'd0) begin
      errors++; $display("FAIL reset_clocked got %h exp %h", dut_v, 31'd0);
    end
  endtask

  // Default 720p timing from reset, 26 lines: line period, hs width, vs edge, first active line.
  task automatic test_default();
    int last_ls = -1, hs_cnt = 0, de_run = 0, first_de = -1;
    en = 1'b1;
    model_reset(ModeDef);
    #2 rst = 1'b0;
    for (int c = 0; c < 26 * 1650 + 300; c++) begin
      step_model(1'b0, ModeDef);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL default_sb c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      if (c == 0) begin
        checks++;
        if ({frame_start, line_start, hs} !== 3'b111) begin
          errors++; $display("FAIL default_first fs/ls/hs=%b exp 111", {frame_start, line_start, hs});
        end
      end
      if (line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (c - last_ls != 1650) begin
            errors++; $display("FAIL line_period got %0d exp 1650", c - last_ls);
          end
        end
        last_ls = c;
      end
      if (c < 1650 && hs) hs_cnt++;
      if (c == 5 * 1650 - 1 || c == 5 * 1650) begin
        checks++;
        if (vs !== (c == 5 * 1650 - 1)) begin
          errors++; $display("FAIL vs_edge c=%0d got %b", c, vs);
        end
      end
      if (de) begin
        if (first_de < 0) first_de = c;
        de_run++;
        if (de_run == 1280) begin
          checks++;
          if (active_x !== 12'd1279 || active_y !== 12'd0) begin
            errors++; $display("FAIL last_pixel x=%0d y=%0d exp 1279 0", active_x, active_y);
          end
        end
      end else if (de_run > 0) begin
        checks++;
        if (de_run != 1280) begin
          errors++; $display("FAIL de_run got %0d exp 1280", de_run);
        end
        de_run = 0;
      end
    end
    checks++;
    if (hs_cnt != 40) begin
      errors++; $display("FAIL hs_width got %0d exp 40", hs_cnt);
    end
    checks++;
    if (first_de != 25 * 1650 + 260) begin
      errors++; $display("FAIL first_de got %0d exp %0d", first_de, 25 * 1650 + 260);
    end
  endtask

  // Disable, load small mode while idle (applies at once), run two frames.
  task automatic test_small_mode();
    int fs_n = 0;
    en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut_v !== 31'd0) begin
      errors++; $display("FAIL en_low got %h exp %h", dut_v, 31'd0);
    end
    set_cfg(ModeSmall);
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1) begin
      errors++; $display("FAIL idle_pending_set got %b exp 1", cfg_pending);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_pending !== 1'b0) begin
      errors++; $display("FAIL idle_apply got %b exp 0", cfg_pending);
    end
    model_reset(ModeSmall);
    en = 1'b1;
    for (int c = 0; c < 96; c++) begin
      step_model(1'b0, ModeSmall);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL small_sb c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      if (frame_start) begin
        fs_n++;
        checks++;
        if (c != 0 && c != 48) begin
          errors++; $display("FAIL small_fs_pos got %0d exp 0 or 48", c);
        end
      end
      if (c == 19 || c == 22) begin
        checks++;
        if (de !== 1'b1 || active_x !== 12'(c - 19) || active_y !== 12'd0) begin
          errors++; $display("FAIL small_px c=%0d de=%b x=%0d y=%0d", c, de, active_x, active_y);
        end
      end
      if (c == 23 || c == 18) begin
        checks++;
        if (de !== 1'b0) begin
          errors++; $display("FAIL small_de_edge c=%0d got %b exp 0", c, de);
        end
      end
      if (c == 35) begin
        checks++;
        if (active_y !== 12'd2) begin
          errors++; $display("FAIL small_row got %0d exp 2", active_y);
        end
      end
    end
    checks++;
    if (fs_n != 2) begin
      errors++; $display("FAIL small_fs_count got %0d exp 2", fs_n);
    end
  endtask

  task automatic test_de_pre();
    int pre_n = 0, bad = 0;
    for (int c = 0; c < 48; c++) begin
      step_model(1'b0, ModeSmall);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL pre_sb c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      if (de_pre) begin
        pre_n++;
        if (c / 8 < 2 || c / 8 > 4 || c % 8 < 1 || c % 8 > 4) bad++;
      end
    end
    checks++;
    if (pre_n != 12) begin
      errors++; $display("FAIL pre_count got %0d exp 12", pre_n);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL pre_position got %0d stray exp 0", bad);
    end
  endtask

  // Polarity change requested mid-frame takes effect at the next frame_start.
  task automatic test_mid_frame_cfg();
    logic load;
    set_cfg(ModeSmallN);
    for (int c = 0; c < 56; c++) begin
      load     = (c == 20);
      cfg_load = load;
      step_model(load, ModeSmallN);
      @(posedge clk); #1;
      cfg_load = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL mid_sb c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      if (c == 20) begin
        checks++;
        if (cfg_pending !== 1'b1) begin
          errors++; $display("FAIL mid_pending got %b exp 1", cfg_pending);
        end
      end
      if (c == 40) begin
        checks++;
        if ({line_start, hs} !== 2'b11) begin
          errors++; $display("FAIL mid_old_pol ls/hs=%b exp 11", {line_start, hs});
        end
      end
      if (c == 48) begin
        checks++;
        if ({frame_start, hs, vs, cfg_pending} !== 4'b1000) begin
          errors++;
          $display("FAIL mid_new_pol fs/hs/vs/pend=%b exp 1000", {frame_start, hs, vs, cfg_pending});
        end
      end
    end
  endtask

  // Load on the wrap edge: skipped by that frame_start, applied at the following one.
  task automatic test_wrap_load();
    logic load;
    logic done = 1'b0;
    int   fs_n = 0;
    set_cfg(ModeSmall);
    for (int c = 0; c < 100; c++) begin
      load     = !done && m_h == 7 && m_v == 5;
      done     = done | load;
      cfg_load = load;
      step_model(load, ModeSmall);
      @(posedge clk); #1;
      cfg_load = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL wrap_sb c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      if (frame_start) begin
        fs_n++;
        checks++;
        if (fs_n == 1 && {hs, cfg_pending} !== 2'b01) begin
          errors++; $display("FAIL wrap_first hs/pend=%b exp 01", {hs, cfg_pending});
        end else if (fs_n == 2 && {hs, cfg_pending} !== 2'b10) begin
          errors++; $display("FAIL wrap_second hs/pend=%b exp 10", {hs, cfg_pending});
        end
      end
    end
    checks++;
    if (fs_n != 2) begin
      errors++; $display("FAIL wrap_fs_count got %0d exp 2", fs_n);
    end
  endtask

  // Reset mid-line with a pending set, then release with en held high.
  task automatic test_reset_mid();
    logic load;
    logic hit = 1'b0;
    set_cfg(ModeSmallN);
    for (int c = 0; c < 40 && !hit; c++) begin
      load     = (c == 0);
      cfg_load = load;
      step_model(load, ModeSmallN);
      @(posedge clk); #1;
      cfg_load = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL rstmid_sb c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      hit = line_start && !frame_start;
    end
    checks++;
    if (!hit || {hs, cfg_pending} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pre hit=%b hs/pend=%b exp 11", hit, {hs, cfg_pending});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_v !== 31'd0) begin
      errors++; $display("FAIL rstmid_async got %h exp %h", dut_v, 31'd0);
    end
    #2 rst = 1'b0;
    model_reset(ModeDef);
    for (int c = 0; c < 30; c++) begin
      step_model(1'b0, ModeDef);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL rstmid_post c=%0d got %h exp %h", c, dut_v, exp_v);
      end
      if (c == 0) begin
        checks++;
        if ({frame_start, line_start, hs} !== 3'b111) begin
          errors++; $display("FAIL rstmid_fs fs/ls/hs=%b exp 111", {frame_start, line_start, hs});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_small_mode();
    test_de_pre();
    test_mid_frame_cfg();
    test_wrap_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Runtime-programmable video timing generator. Successor to the fixed-mode 720p timing block, with generalised counter width.
- Produces hs/vs/de, pixel coordinates, line/frame strobes and an early-fetch strobe (de_pre) for the frame-buffer read path.
- Mode changes are double-buffered: captured on cfg_load and applied only at a frame boundary, so the HDMI/DVI encoder never sees a torn frame.
- Sits between the pixel-clock domain frame reader and the TMDS encoder.

Parameters:
- CNT_W, 12, width of counters, coordinates and cfg fields.
- RST_H_ACTIVE/H_FP/H_SYNC/H_BP, 1280/110/40/220, horizontal timing loaded into the active set at reset.
- RST_V_ACTIVE/V_FP/V_SYNC/V_BP, 720/5/5/20, vertical timing loaded at reset.
- RST_HS_POL/RST_VS_POL, 1/1, sync polarity loaded at reset (1 = positive).
- PRE, 2, lead of de_pre over de in cycles. Legal range 0..RST-independent min(h_sync+h_bp).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable; low holds the generator idle
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CNT_W each  requested horizontal timing
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CNT_W each  requested vertical timing
- cfg_hs_pol, cfg_vs_pol  in  1 each  requested sync polarity
- cfg_load  in  1  single-cycle pulse; captures all cfg_* into the pending set
- cfg_pending  out  1  pending set captured but not yet applied
- hs  out  1  horizontal sync, polarity per active set
- vs  out  1  vertical sync, polarity per active set
- de  out  1  active video
- de_pre  out  1  de advanced by PRE cycles
- active_x  out  CNT_W  pixel column, 0 when de low
- active_y  out  CNT_W  pixel row, 0 when de low
- line_start  out  1  one-cycle pulse, first cycle of every line
- frame_start  out  1  one-cycle pulse, first cycle of every frame

Behaviour:
- Line layout, h_cnt 0..HT-1 with HT = h_sync+h_bp+h_active+h_fp:
  - sync [0, h_sync)
  - back porch up to HA0 = h_sync+h_bp
  - active [HA0, HA0+h_active)
  - front porch to end of line
- Frame layout, v_cnt 0..VT-1: same ordering with v_* fields. VA0 = v_sync+v_bp.
- v_cnt advances when h_cnt wraps HT-1 -> 0. v_cnt wraps VT-1 -> 0.
- All outputs are registered functions of (h_cnt, v_cnt) with exactly one cycle of latency.
- hs = pol XOR ~(h_cnt < h_sync).
- vs = pol XOR ~(v_cnt < v_sync). vs changes only with h_cnt = 0, i.e. it is line-aligned.
- de = (h_cnt in active) AND (v_cnt in active).
  - active_x = h_cnt - HA0 and active_y = v_cnt - VA0 while de is high; both outputs are 0 otherwise.
- de_pre: asserted when h_cnt is in [HA0-PRE, HA0+h_active-PRE) and the line is vertically active. PRE = 0 gives de_pre identical to de.
- line_start asserts for the counter state h_cnt = 0. frame_start asserts for the counter state h_cnt = 0 AND v_cnt = 0.
- Reset:
  - Counters are 0 and the active set is loaded from the RST_* parameters.
  - pending is cleared.
  - Outputs: de = de_pre = line_start = frame_start = 0, active_x = active_y = 0, hs = ~RST_HS_POL, vs = ~RST_VS_POL (deasserted).
- en low:
  - Counters are forced to 0 and outputs take their reset values, using the active-set polarities for hs/vs.
  - On en rising, the first counter state is (0,0), so the first output cycle after that carries frame_start.
- Config:
  - cfg_load captures all cfg_* fields into the pending set and sets cfg_pending in the next cycle.
  - The pending set is copied to the active set on the cycle the counters wrap to (0,0), or immediately while en is low. cfg_pending clears on the same edge.
  - A second cfg_load before the set is applied overwrites the pending set (last write wins).
  - cfg_load coincident with the wrap: the newly captured values are held pending and applied at the next frame, not the current wrap.
- Arithmetic: all sums are computed at CNT_W+1 bits to detect overflow. Configurations with HT > 2^CNT_W, VT > 2^CNT_W, or any sync/active field equal to 0 are illegal; behaviour for them is unspecified, but the block must not lock up.
- Reset mid-frame aborts the frame immediately; no partial-state retention.

Test Plan:
- Reset defaults, en=1:
  - 1650 cycles between line_start pulses and 1650*750 cycles between frame_start pulses.
  - de high for 1280 consecutive cycles per active line and 720 active lines per frame.
  - hs high for 40 cycles, starting on the line_start cycle.
- Small mode h=(act 4, fp 1, sync 2, bp 1), v=(act 3, fp 1, sync 1, bp 1), loaded with cfg_load while en=0 (applied immediately):
  - HT = 8; de on line cycles 3-6 with active_x 0,1,2,3.
  - active_y 0..2 on lines 2..4; frame length 48 cycles.
- PRE=2 on the small mode: de_pre is high on cycles 1-4 of each active line, exactly 2 cycles ahead of de, and never high on vertically inactive lines.
- Mid-frame cfg_load switching small mode -> polarity 0 on both syncs:
  - cfg_pending goes high the next cycle.
  - The old timing completes the frame.
  - The new polarity takes effect from the frame_start cycle and cfg_pending clears on it.
- cfg_load pulsed on the wrap cycle: the new values are not applied at this frame_start but at the following one.
- Assert rst mid-line, then release with en held high: all outputs return to reset values asynchronously, and frame_start appears on the first output cycle after release.
